// File: rtl/bufgmux_sel_ctrl.sv
// bufgmux_sel_ctrl: sequencer for a PLL -> BUFG -> BUFGMUX clock-selection path.
// Runs on the always-on reference clock. It pulses the PLL reset and waits for
// LOCKED to stay stable. It then debounces an asynchronous select request and
// moves the BUFGMUX S input only while the PLL is locked, leaving idle windows
// before and after each move. If lock does not arrive in time, the PLL is
// restarted.
//
// Ports:
//   clk           reference clock (all logic in this domain)
//   rst_n         asynchronous active-low reset
//   sel_req_i     raw select request, asynchronous (board switch etc.)
//   pll_locked_i  PLL LOCKED, asynchronous
//   pll_rst_o     PLL RST, active high
//   mux_sel_o     BUFGMUX S
//   sel_valid_o   1 = PLL locked and mux settled on mux_sel_o
//   busy_o        1 whenever the sequencer is not in RUN
//   timeout_o     one-cycle pulse when a lock timeout restarts the PLL
//
// Optional build macro BUFGMUX_SEL_CTRL_STATS_EN adds:
//   switch_cnt_o  [15:0] mux toggles, wrapping
//   relock_cnt_o  [7:0]  lock losses out of RUN/HOLDOFF/SETTLE, saturating
module bufgmux_sel_ctrl #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_SETTLE_CYCLES  = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned DEBOUNCE_CYCLES     = 16,
    parameter int unsigned HOLDOFF_CYCLES      = 8,
    parameter bit          DEFAULT_SEL         = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_req_i,
    input  logic        pll_locked_i,
    output logic        pll_rst_o,
    output logic        mux_sel_o,
    output logic        sel_valid_o,
    output logic        busy_o,
    output logic        timeout_o
`ifdef BUFGMUX_SEL_CTRL_STATS_EN
    ,
    output logic [15:0] switch_cnt_o,
    output logic [7:0]  relock_cnt_o
`endif
);

    // A single phase counter serves RESET_PLL, HOLDOFF and SETTLE. These
    // states never overlap, so it is sized for the larger of the two lengths.
    localparam int unsigned PH_MAX = (PLL_RST_CYCLES > HOLDOFF_CYCLES) ?
                                     PLL_RST_CYCLES : HOLDOFF_CYCLES;
    localparam int PW = $clog2(PH_MAX + 1);
    localparam int SW = $clog2(LOCK_SETTLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    // Each counter stops at N-1, so the action fires on the Nth counted edge.
    localparam logic [PW-1:0] RST_LAST    = PW'(PLL_RST_CYCLES - 1);
    localparam logic [PW-1:0] HOLD_LAST   = PW'(HOLDOFF_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        RUN,
        HOLDOFF,
        SETTLE
    } state_t;

    state_t        state;
    logic          req_s1, req_sync;
    logic          lock_s1, locked_sync;
    logic          deb_sel;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] ph_cnt;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] tmo_cnt;

    // Two-flop synchronizers for both asynchronous inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1      <= 1'b0;
            req_sync    <= 1'b0;
            lock_s1     <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            req_s1      <= sel_req_i;
            req_sync    <= req_s1;
            lock_s1     <= pll_locked_i;
            locked_sync <= lock_s1;
        end
    end

    // Debounce runs in every state. Any cycle on which the request agrees
    // with the accepted value restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_sel <= DEFAULT_SEL;
            deb_cnt <= '0;
        end else if (req_sync != deb_sel) begin
            if (deb_cnt == DEB_LAST) begin
                deb_sel <= req_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RESET_PLL;
            pll_rst_o    <= 1'b1;
            mux_sel_o    <= DEFAULT_SEL;
            sel_valid_o  <= 1'b0;
            busy_o       <= 1'b1;
            timeout_o    <= 1'b0;
            ph_cnt       <= '0;
            settle_cnt   <= '0;
            tmo_cnt      <= '0;
`ifdef BUFGMUX_SEL_CTRL_STATS_EN
            switch_cnt_o <= '0;
            relock_cnt_o <= '0;
`endif
        end else begin
            timeout_o <= 1'b0;
            case (state)
                RESET_PLL: begin
                    pll_rst_o   <= 1'b1;
                    mux_sel_o   <= DEFAULT_SEL;
                    sel_valid_o <= 1'b0;
                    busy_o      <= 1'b1;
                    settle_cnt  <= '0;
                    tmo_cnt     <= '0;
                    if (ph_cnt == RST_LAST) begin
                        ph_cnt    <= '0;
                        pll_rst_o <= 1'b0;
                        state     <= WAIT_LOCK;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    mux_sel_o <= DEFAULT_SEL;
                    // A completed settle wins over a timeout on the same cycle.
                    if (locked_sync && settle_cnt == SETTLE_LAST) begin
                        state       <= RUN;
                        sel_valid_o <= 1'b1;
                        busy_o      <= 1'b0;
                        settle_cnt  <= '0;
                        tmo_cnt     <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= RESET_PLL;
                        pll_rst_o  <= 1'b1;
                        timeout_o  <= 1'b1;
                        settle_cnt <= '0;
                        tmo_cnt    <= '0;
                    end else begin
                        tmo_cnt    <= tmo_cnt + 1'b1;
                        settle_cnt <= locked_sync ? settle_cnt + 1'b1 : '0;
                    end
                end

                RUN, HOLDOFF, SETTLE: begin
                    if (!locked_sync) begin
                        // Lock loss overrides any pending or in-flight switch.
                        // The mux is parked on the default input.
                        state       <= WAIT_LOCK;
                        mux_sel_o   <= DEFAULT_SEL;
                        sel_valid_o <= 1'b0;
                        busy_o      <= 1'b1;
                        ph_cnt      <= '0;
                        settle_cnt  <= '0;
                        tmo_cnt     <= '0;
`ifdef BUFGMUX_SEL_CTRL_STATS_EN
                        if (relock_cnt_o != 8'hFF)
                            relock_cnt_o <= relock_cnt_o + 1'b1;
`endif
                    end else if (state == RUN) begin
                        // The request is only looked at here, so a change
                        // during HOLDOFF/SETTLE cannot abort a switch.
                        if (deb_sel != mux_sel_o) begin
                            state       <= HOLDOFF;
                            sel_valid_o <= 1'b0;
                            busy_o      <= 1'b1;
                            ph_cnt      <= '0;
                        end
                    end else if (state == HOLDOFF) begin
                        if (ph_cnt == HOLD_LAST) begin
                            mux_sel_o <= ~mux_sel_o;
                            ph_cnt    <= '0;
                            state     <= SETTLE;
`ifdef BUFGMUX_SEL_CTRL_STATS_EN
                            switch_cnt_o <= switch_cnt_o + 1'b1;
`endif
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end else begin
                        if (ph_cnt == HOLD_LAST) begin
                            state       <= RUN;
                            sel_valid_o <= 1'b1;
                            busy_o      <= 1'b0;
                            ph_cnt      <= '0;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= RESET_PLL;
                    pll_rst_o <= 1'b1;
                    mux_sel_o <= DEFAULT_SEL;
                    ph_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/bufgmux_sel_ctrl.md
Name: bufgmux_sel_ctrl

Overview:
- Sequencer for a PLL → BUFG → BUFGMUX clock-selection path. Runs on the always-on reference clock (the input BUFG output).
- Brings the PLL out of reset and qualifies LOCKED. It then takes an asynchronous user select request, such as a board switch, and debounces it.
- Drives the BUFGMUX S input only when the PLL is locked, with hold-off and settle windows around each switch.
- Reports whether the selected output clock is currently trustworthy. Restarts the PLL if lock is not achieved in time.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst_o is held high per PLL reset pulse (≥1).
- LOCK_SETTLE_CYCLES, 64: consecutive synchronized-locked cycles required before the lock is trusted (≥1).
- LOCK_TIMEOUT_CYCLES, 4096: cycles allowed in WAIT_LOCK before the PLL is reset again (> LOCK_SETTLE_CYCLES).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles of the synchronized request before it is accepted (≥1).
- HOLDOFF_CYCLES, 8: idle cycles before and after toggling mux_sel_o (≥1).
- DEFAULT_SEL, 0: select value forced at reset and on lock loss.

Ports:
- clk, input, 1: reference clock; all logic is in this domain.
- rst_n, input, 1: asynchronous active-low reset.
- sel_req_i, input, 1: raw select request, asynchronous.
- pll_locked_i, input, 1: PLL LOCKED, asynchronous.
- pll_rst_o, output, 1: PLL RST, active high.
- mux_sel_o, output, 1: BUFGMUX S.
- sel_valid_o, output, 1: 1 = PLL locked and mux settled on mux_sel_o.
- busy_o, output, 1: 1 whenever the state is not RUN.
- timeout_o, output, 1: one-cycle pulse when a lock timeout triggers a PLL reset.

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - state = RESET_PLL
  - pll_rst_o = 1, mux_sel_o = DEFAULT_SEL
  - sel_valid_o = 0, busy_o = 1, timeout_o = 0
  - debounced request = DEFAULT_SEL
  - all counters = 0
  - synchronizer flops = 0
- Synchronizers:
  - 2-flop synchronizer on sel_req_i; 2-flop synchronizer on pll_locked_i.
  - Latency is 2 cycles.
- Debounce:
  - A counter runs while the synchronized request differs from the debounced value. It clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the request and the counter clears.
  - Debounce runs in every state.
- States:
  - RESET_PLL: pll_rst_o = 1; count PLL_RST_CYCLES, then go to WAIT_LOCK with pll_rst_o = 0.
  - WAIT_LOCK: mux_sel_o = DEFAULT_SEL.
    - The settle counter increments while locked_sync = 1 and clears when it is 0.
    - Settle count = LOCK_SETTLE_CYCLES → RUN.
    - Otherwise, timeout counter = LOCK_TIMEOUT_CYCLES → RESET_PLL, with timeout_o pulsed for 1 cycle.
    - The timeout counter clears on entry.
  - RUN: sel_valid_o = 1, busy_o = 0.
    - debounced ≠ mux_sel_o → HOLDOFF.
  - HOLDOFF: sel_valid_o = 0.
    - Count HOLDOFF_CYCLES, then invert mux_sel_o in the same cycle and go to SETTLE.
  - SETTLE: count HOLDOFF_CYCLES, then go to RUN.
    - If debounced ≠ mux_sel_o on return, the next switch starts immediately.
- Lock loss: locked_sync = 0 in RUN, HOLDOFF or SETTLE goes to WAIT_LOCK next cycle. On the same edge:
  - sel_valid_o = 0
  - mux_sel_o = DEFAULT_SEL
  - counters clear
- Lock loss has priority over a pending or in-progress switch.
- The request is re-evaluated in RUN only, so a change during HOLDOFF/SETTLE does not abort the switch.
- mux_sel_o and sel_valid_o are registered outputs.
- At most one mux_sel_o change per 2×HOLDOFF_CYCLES+1 cycles.
- The sel_valid_o = 0 window fully covers every mux_sel_o edge.

Optional Feature:
- Macro: BUFGMUX_SEL_CTRL_STATS_EN.
- When defined, adds two outputs:
  - switch_cnt_o [15:0]: increments on each mux_sel_o toggle in HOLDOFF and wraps 0xFFFF → 0.
  - relock_cnt_o [7:0]: increments on each lock-loss exit from RUN/HOLDOFF/SETTLE and saturates at 0xFF.
- Both reset to 0.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan (PLL_RST=4, SETTLE=8, TIMEOUT=32, DEBOUNCE=4, HOLDOFF=3, DEFAULT_SEL=0):
- Bring-up: release rst_n with locked=0 → pll_rst_o high exactly 4 cycles. Then raise locked → sel_valid_o=1 on cycle 2+8 after the first edge sampling locked=1; mux_sel_o=0.
- Switch: in RUN, hold sel_req_i=1 → debounce accepts after 2+4 cycles; sel_valid_o falls; mux_sel_o goes 0→1 after 3 cycles; sel_valid_o rises 3 cycles later.
- Glitch reject: 3-cycle pulses on sel_req_i → mux_sel_o stays 0, sel_valid_o stays 1, busy_o stays 0.
- Lock loss mid-switch: drop locked during SETTLE with mux_sel_o=1 → 2 cycles later mux_sel_o=0 and sel_valid_o=0, state WAIT_LOCK. Relock plus 8 stable cycles → switch back to 1.
- Timeout: hold locked=0 → timeout_o pulses after 32 WAIT_LOCK cycles, then pll_rst_o high 4 cycles; repeats until lock.
- Async reset mid-HOLDOFF: assert rst_n low → outputs go to reset values immediately, without a clock edge. With STATS_EN defined, the counters read 0.
